// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Streaming RV32I instruction encoder. Takes an instruction format plus its
// raw fields and assembles the 32-bit instruction word. Each word is range
// checked and tagged with a sequential instruction-memory word address.
//
// Two-stage pipeline:
//   S1 holds the raw fields as accepted from the input port.
//   S2 holds the encoded word, its error code and its address (drives out_*).
//
// Handshake: a transfer happens on a port in any cycle where valid and ready
// are both high. Upstream holds its fields stable while in_valid is high and
// in_ready is low; this block holds out_* stable while out_valid is high and
// out_ready is low.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous flush of both stages + address reload
//   in_valid/ready  input handshake
//   fmt             0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   out_valid/ready output handshake
//   out_instr       encoded word (zero when errored)
//   out_addr        word address of out_instr
//   out_err         0=ok 1=imm range 2=misaligned 3=illegal fmt
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT   = 2'd3;

    // S1: raw fields
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_fmt_q, s1_fmt_d;
    logic [6:0]  s1_opcode_q, s1_opcode_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic [4:0]  s1_rs1_q, s1_rs1_d;
    logic [4:0]  s1_rs2_q, s1_rs2_d;
    logic [2:0]  s1_funct3_q, s1_funct3_d;
    logic [6:0]  s1_funct7_q, s1_funct7_d;
    logic [31:0] s1_imm_q, s1_imm_d;

    // S2: encoded word
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_instr_q, s2_instr_d;
    logic [1:0]        s2_err_q, s2_err_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;

    // Address of the next ok word to be emitted
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic        s2_free;
    logic        in_hs;
    logic        out_hs;
    logic        move;
    logic        cnt_inc;
    logic [31:0] enc_instr;
    logic [1:0]  enc_err;

    // in_ready is forced low during rst and clear so that no input handshake
    // can happen in a cycle whose effects are about to be discarded.
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        in_ready = !rst && !clear && (!s1_valid_q || s2_free);
        in_hs    = in_valid && in_ready;
        out_hs   = s2_valid_q && out_ready && !clear;
        move     = s1_valid_q && s2_free;
        // Errored words carry the current address but do not consume it.
        cnt_inc  = out_hs && (s2_err_q == ERR_OK);
    end

    // Encoder and checks on the S1 fields. Priority: fmt, alignment, range.
    always_comb begin
        enc_instr = '0;
        enc_err   = ERR_OK;
        case (s1_fmt_q)
            FMT_R: begin
                enc_instr = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            end
            FMT_I: begin
                enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                if ($signed(s1_imm_q) < -32'sd2048 || $signed(s1_imm_q) > 32'sd2047) begin
                    enc_err = ERR_RANGE;
                end
            end
            FMT_S: begin
                enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:0], s1_opcode_q};
                if ($signed(s1_imm_q) < -32'sd2048 || $signed(s1_imm_q) > 32'sd2047) begin
                    enc_err = ERR_RANGE;
                end
            end
            FMT_B: begin
                enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
                if (s1_imm_q[0]) begin
                    enc_err = ERR_ALIGN;
                end else if ($signed(s1_imm_q) < -32'sd4096 ||
                             $signed(s1_imm_q) > 32'sd4094) begin
                    enc_err = ERR_RANGE;
                end
            end
            FMT_U: begin
                enc_instr = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
                if (s1_imm_q[11:0] != 12'd0) begin
                    enc_err = ERR_ALIGN;
                end
            end
            FMT_J: begin
                enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, s1_opcode_q};
                if (s1_imm_q[0]) begin
                    enc_err = ERR_ALIGN;
                end else if ($signed(s1_imm_q) < -32'sd1048576 ||
                             $signed(s1_imm_q) > 32'sd1048574) begin
                    enc_err = ERR_RANGE;
                end
            end
            default: begin
                enc_err = ERR_FMT;
            end
        endcase
        if (enc_err != ERR_OK) begin
            enc_instr = '0;
        end
    end

    // Next-state for both stages and the counter; clear wins over everything.
    always_comb begin
        s1_fmt_d    = s1_fmt_q;
        s1_opcode_d = s1_opcode_q;
        s1_rd_d     = s1_rd_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_funct3_d = s1_funct3_q;
        s1_funct7_d = s1_funct7_q;
        s1_imm_d    = s1_imm_q;
        if (in_hs) begin
            s1_fmt_d    = fmt;
            s1_opcode_d = opcode;
            s1_rd_d     = rd;
            s1_rs1_d    = rs1;
            s1_rs2_d    = rs2;
            s1_funct3_d = funct3;
            s1_funct7_d = funct7;
            s1_imm_d    = imm;
        end

        cnt_d      = cnt_q + ADDR_W'(cnt_inc);
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        s2_addr_d  = s2_addr_q;

        if (clear) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s2_instr_d = '0;
            s2_err_d   = ERR_OK;
            s2_addr_d  = BASE;
            cnt_d      = BASE;
        end else begin
            if (in_hs) begin
                s1_valid_d = 1'b1;
            end else if (move) begin
                s1_valid_d = 1'b0;
            end

            if (move) begin
                s2_valid_d = 1'b1;
                s2_instr_d = enc_instr;
                s2_err_d   = enc_err;
                // cnt_d already includes a same-cycle ok output handshake.
                s2_addr_d  = cnt_d;
            end else if (out_hs) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_err_q    <= ERR_OK;
            s2_addr_q   <= BASE;
            cnt_q       <= BASE;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_opcode_q <= s1_opcode_d;
            s1_rd_q     <= s1_rd_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_funct3_q <= s1_funct3_d;
            s1_funct7_q <= s1_funct7_d;
            s1_imm_q    <= s1_imm_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            s2_addr_q   <= s2_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign out_addr  = s2_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A driver process feeds words from a
// stimulus queue and, on each input handshake, pushes the expected
// {err, instr} into exp_q. A monitor pops exp_q on each output handshake and
// compares word, error and address; the address is tracked as a running
// count of ok words emitted since the last reset/clear.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 0;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [1:0]        out_err;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        has_exp;
        logic [33:0] exp_word;
    } stim_t;

    stim_t       stim_q[$];
    logic [33:0] exp_q[$];
    int          model_cnt;
    int          tests;
    int          fails;

    int edge_tab [14] = '{-4096, -4097, 4094, 4095, -2048, -2049, 2047, 2048,
                          1048574, -1048576, 1048576, -1048578, 3, 0};

    // ---------------- reference model ----------------
    function automatic longint bits(input longint v, input int hi, input int lo);
        return (v >>> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic logic [33:0] ref_encode(input stim_t s);
        longint     v;
        longint     w;
        logic [1:0] e;
        logic [63:0] wb;
        v = longint'($signed(s.imm));
        w = 0;
        e = 2'd0;
        case (int'(s.fmt))
            0: w = (longint'(s.funct7) << 25) + (longint'(s.rs2) << 20) +
                   (longint'(s.rs1) << 15) + (longint'(s.funct3) << 12) +
                   (longint'(s.rd) << 7) + longint'(s.opcode);
            1: begin
                w = (bits(v, 11, 0) << 20) + (longint'(s.rs1) << 15) +
                    (longint'(s.funct3) << 12) + (longint'(s.rd) << 7) + longint'(s.opcode);
                if (v < -2048 || v > 2047) e = 2'd1;
            end
            2: begin
                w = (bits(v, 11, 5) << 25) + (longint'(s.rs2) << 20) + (longint'(s.rs1) << 15) +
                    (longint'(s.funct3) << 12) + (bits(v, 4, 0) << 7) + longint'(s.opcode);
                if (v < -2048 || v > 2047) e = 2'd1;
            end
            3: begin
                w = (bits(v, 12, 12) << 31) + (bits(v, 10, 5) << 25) + (longint'(s.rs2) << 20) +
                    (longint'(s.rs1) << 15) + (longint'(s.funct3) << 12) +
                    (bits(v, 4, 1) << 8) + (bits(v, 11, 11) << 7) + longint'(s.opcode);
                if (bits(v, 0, 0) != 0) e = 2'd2;
                else if (v < -4096 || v > 4094) e = 2'd1;
            end
            4: begin
                w = (bits(v, 31, 12) << 12) + (longint'(s.rd) << 7) + longint'(s.opcode);
                if (bits(v, 11, 0) != 0) e = 2'd2;
            end
            5: begin
                w = (bits(v, 20, 20) << 31) + (bits(v, 10, 1) << 21) + (bits(v, 11, 11) << 20) +
                    (bits(v, 19, 12) << 12) + (longint'(s.rd) << 7) + longint'(s.opcode);
                if (bits(v, 0, 0) != 0) e = 2'd2;
                else if (v < -1048576 || v > 1048574) e = 2'd1;
            end
            default: e = 2'd3;
        endcase
        if (e != 2'd0) w = 0;
        wb = 64'(w);
        return {e, wb[31:0]};
    endfunction

    function automatic stim_t mk(input int f, input int op, input int rdi, input int r1,
                                 input int r2, input int f3, input int f7,
                                 input logic [31:0] im, input logic has,
                                 input logic [33:0] ew);
        stim_t s;
        s.fmt = 3'(f); s.opcode = 7'(op); s.rd = 5'(rdi); s.rs1 = 5'(r1); s.rs2 = 5'(r2);
        s.funct3 = 3'(f3); s.funct7 = 7'(f7); s.imm = im;
        s.has_exp = has; s.exp_word = ew;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = mk($urandom_range(0, 5), $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, 1'b0, '0);
        if ($urandom_range(0, 9) == 0) s.fmt = 3'($urandom_range(6, 7));
        case ($urandom_range(0, 3))
            0: s.imm = $urandom;
            1: s.imm = 32'($urandom_range(0, 16383)) - 32'd8192;
            2: s.imm = 32'(edge_tab[$urandom_range(0, 13)]);
            default: s.imm = $urandom & 32'hFFFF_F000;
        endcase
        return s;
    endfunction

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || in_valid || exp_q.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL drain_%s: timeout with %0d expected words outstanding",
                     tag, exp_q.size());
        end
    endtask

    task automatic wait_accepts(input int n, input string tag);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (in_valid && in_ready) got++;
        end
        tests++;
        if (got < n) begin
            fails++;
            $display("FAIL accept_%s: got %0d accepts expected %0d", tag, got, n);
        end
    endtask

    // ---------------- driver ----------------
    initial begin : driver
        stim_t cur;
        logic  took;
        cur = '0;
        in_valid = 1'b0;
        {fmt, opcode, rd, rs1, rs2, funct3, funct7, imm} = '0;
        forever begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) exp_q.push_back(cur.has_exp ? cur.exp_word : ref_encode(cur));
            @(posedge clk);
            #1;
            if (took || !in_valid) begin
                if (stim_q.size() > 0) begin
                    cur = stim_q.pop_front();
                    fmt = cur.fmt; opcode = cur.opcode; rd = cur.rd; rs1 = cur.rs1;
                    rs2 = cur.rs2; funct3 = cur.funct3; funct7 = cur.funct7; imm = cur.imm;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                    {fmt, opcode, rd, rs1, rs2, funct3, funct7, imm} = {$urandom, $urandom};
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic              stall;
        logic [31:0]       h_instr;
        logic [1:0]        h_err;
        logic [ADDR_W-1:0] h_addr;
        logic [33:0]       e;
        logic [ADDR_W-1:0] ea;
        stall = 1'b0;
        h_instr = '0; h_err = '0; h_addr = '0;
        forever begin
            @(negedge clk);
            if (rst || clear) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    tests++;
                    if (!out_valid || out_instr !== h_instr || out_err !== h_err ||
                        out_addr !== h_addr) begin
                        fails++;
                        $display("FAIL hold: got v=%b %h/%0d@%0d expected v=1 %h/%0d@%0d",
                                 out_valid, out_instr, out_err, out_addr, h_instr, h_err, h_addr);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_out: got %h/%0d@%0d expected no word",
                                 out_instr, out_err, out_addr);
                    end else begin
                        e  = exp_q.pop_front();
                        ea = ADDR_W'(model_cnt);
                        if (out_instr !== e[31:0] || out_err !== e[33:32] || out_addr !== ea) begin
                            fails++;
                            $display("FAIL word: got %h err %0d addr %0d expected %h err %0d addr %0d",
                                     out_instr, out_err, out_addr, e[31:0], e[33:32], ea);
                        end
                        if (e[33:32] == 2'd0) model_cnt = (model_cnt + 1) % (1 << ADDR_W);
                    end
                end
                stall   = out_valid && !out_ready;
                h_instr = out_instr;
                h_err   = out_err;
                h_addr  = out_addr;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d expected words left", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        rst = 1'b1; clear = 1'b0; out_ready = 1'b1;
        tests = 0; fails = 0; model_cnt = BASE_ADDR;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // single words with latency check on the first
        stim_q.push_back(mk(1, 'h13, 1, 0, 9, 0, 'h55, 5, 1'b1, {2'd0, 32'h0050_0093}));
        wait_accepts(1, "latency");
        @(negedge clk);
        check("latency_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_n2", 32'(out_valid), 32'd1);
        stim_q.push_back(mk(0, 'h33, 3, 1, 2, 0, 0, 32'h7FF, 1'b1, {2'd0, 32'h0020_81B3}));
        stim_q.push_back(mk(2, 'h23, 7, 1, 2, 2, 0, 8, 1'b1, {2'd0, 32'h0020_A423}));
        drain("single");

        // boundary immediates
        stim_q.push_back(mk(3, 'h63, 7, 0, 0, 0, 0, -4, 1'b1, {2'd0, 32'hFE00_0EE3}));
        stim_q.push_back(mk(5, 'h6F, 1, 3, 3, 0, 0, 2048, 1'b1, {2'd0, 32'h0010_00EF}));
        stim_q.push_back(mk(4, 'h37, 5, 3, 3, 1, 0, 32'h1234_5000, 1'b1, {2'd0, 32'h1234_52B7}));
        drain("boundary");

        // errors, then a valid word reusing the address
        stim_q.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 3, 1'b1, {2'd2, 32'h0}));
        stim_q.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 2048, 1'b1, {2'd1, 32'h0}));
        stim_q.push_back(mk(6, 'h13, 1, 0, 0, 0, 0, 0, 1'b1, {2'd3, 32'h0}));
        stim_q.push_back(mk(1, 'h13, 2, 1, 0, 0, 0, -2048, 1'b0, '0));
        drain("errors");

        // clear with words in flight and a simultaneous input
        for (int i = 0; i < 6; i++) stim_q.push_back(mk(0, 'h33, i, i, i, 0, 0, 0, 1'b0, '0));
        wait_accepts(3, "pre_clear");
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        check("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        model_cnt = BASE_ADDR;
        check("clear_out_valid", 32'(out_valid), 32'd0);
        drain("after_clear");

        // idle clear to restart addresses, then backpressure and wrap
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_cnt = BASE_ADDR;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) stim_q.push_back(rand_stim());
        for (int i = 0; i < 4; i++) stim_q[i].fmt = 3'd0;
        begin
            int acc;
            acc = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (in_valid && in_ready) acc++;
            end
            check("bp_accepts", 32'(acc), 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("backpressure");
        stim_q.push_back(mk(0, 'h33, 1, 2, 3, 0, 0, 0, 1'b0, '0));
        drain("wrap");

        // randomized traffic with random backpressure
        for (int i = 0; i < 60; i++) stim_q.push_back(rand_stim());
        for (int c = 0; c < 400 && stim_q.size() > 0; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("random");

        // reset mid-stream
        for (int i = 0; i < 6; i++) stim_q.push_back(rand_stim());
        wait_accepts(3, "pre_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        model_cnt = BASE_ADDR;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
        rst = 1'b0;
        drain("after_rst");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the core's field decoder. It accepts an instruction format plus its fields (opcode, registers, funct3/funct7, signed immediate) over a valid/ready handshake and assembles the 32-bit instruction word. Each word is range-checked and tagged with a sequential program-memory word address. It feeds the instruction-memory write port of the program loader and self-test sequencer.

## Interface
Parameters:
- ADDR_W, default 10: word-address width of the target instruction memory.
- BASE_ADDR, default 0: address assigned to the first word after reset or clear.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush: drops both pipeline stages and reloads the address counter.
- in_valid  in  1  input fields are valid.
- in_ready  out  1  encoder accepts the input this cycle.
- fmt  in  3  format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  in  7  instruction bits [6:0].
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  function field.
- funct7  in  7  function field; used by R only.
- imm  in  32  signed immediate. B and J take a byte offset. U takes the full value; bits [31:12] are the field.
- out_valid  out  1  output word is valid.
- out_ready  in  1  downstream accepts the output word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_instr.
- out_err  out  2  error code: 0=ok, 1=immediate out of range, 2=misaligned, 3=illegal fmt.

## Operation
- Two-stage pipeline.
  - S1 registers the raw fields.
  - S2 holds the encoded word, its error code and its address.
- A handshake occurs on a port when valid and ready are both high in the same cycle.
- Encoding uses standard RV32 bit placement. Any field not used by the selected format is ignored.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Checks are evaluated when the word moves S1→S2. Priority is illegal fmt, then misaligned, then range.
  - I and S: imm must be in [-2048, 2047], else code 1.
  - B: imm[0] must be 0, else code 2. imm must be in [-4096, 4094], else code 1.
  - J: imm[0] must be 0, else code 2. imm must be in [-1048576, 1048574], else code 1.
  - U: imm[11:0] must be 0, else code 2.
  - R: imm is not checked.
- An errored word sets out_instr = 0x00000000 and out_err to its nonzero code. It carries the current address but does not advance the counter.
- Address counter:
  - Increments by 1 on each output handshake with out_err = 0.
  - Wraps from 2^ADDR_W−1 to 0 with no flag.
  - out_addr of a word is the counter value when that word enters S2.
- clear:
  - Sets both stage valids to 0 and the counter to BASE_ADDR.
  - Forces in_ready = 0 that cycle; any input or output handshake in that cycle is void.
  - clear overrides every simultaneous event.

## Timing
- Reset values: out_valid 0, out_instr 0, out_err 0, out_addr BASE_ADDR, in_ready 0 while rst is high. in_ready is 1 in the first cycle after rst falls.
- Latency: an input handshake in cycle N gives out_valid in cycle N+2 when there is no backpressure.
- Throughput: one word per cycle while out_ready stays high.
- s2_free = !out_valid || out_ready.
- S1 moves to S2 when S1 is valid and s2_free.
- in_ready = !s1_valid || s2_free. It is combinational from the registered state and out_ready.
- With out_ready held low, at most 2 words are buffered. in_ready falls after the second accepted input.
- While out_valid = 1 and out_ready = 0, out_instr, out_addr and out_err hold stable.
- A simultaneous output handshake and S1→S2 move in the same cycle loads the new word with the incremented address.
- rst mid-stream discards all in-flight words.

## Test plan
- Single words, out_ready tied high, after reset:
  - I: opcode 0x13, rd 1, rs1 0, funct3 0, imm 5 → 0x00500093, addr 0, err 0.
  - R: opcode 0x33, rd 3, rs1 1, rs2 2, funct3 0, funct7 0 → 0x002081B3, addr 1.
  - S: opcode 0x23, rs1 1, rs2 2, funct3 2, imm 8 → 0x0020A423, addr 2.
- Boundary immediates:
  - B: opcode 0x63, rs1 0, rs2 0, funct3 0, imm −4 → 0xFE000EE3.
  - J: opcode 0x6F, rd 1, imm 2048 → 0x001000EF.
  - U: opcode 0x37, rd 5, imm 0x12345000 → 0x123452B7.
  - Each word gets consecutive addresses.
- Errors:
  - B with imm 3 → out_instr 0, out_err 2.
  - I with imm 2048 → out_err 1.
  - fmt 6 → out_err 3.
  - The next valid word reuses the unchanged address.
- Backpressure:
  - Drive 4 back-to-back words with out_ready low for 3 cycles → in_ready low after 2 accepts, outputs held stable.
  - After out_ready is released → all 4 words emerge in order at addresses 0–3.
- clear:
  - Assert clear with 2 words in flight and a simultaneous input → no output, in_ready 0 that cycle.
  - The next word after clear → out_addr BASE_ADDR.
- Wrap:
  - With ADDR_W=2, send 5 valid words → addresses 0, 1, 2, 3, 0.
- Reset:
  - Assert rst mid-stream → out_valid 0, out_addr BASE_ADDR the following cycle.
